spi_rb_bridge: RTL

SPI_RB_BRIDGE -- requirements
Module: spi_rb_bridge

---
 rtl/fpga_template_pkg.sv | 28 ++
 rtl/spi_rb_bridge_if.sv | 39 +++
 rtl/spi_sync.sv | 29 ++
 rtl/spi_rb_bridge.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fpga_template_pkg.sv
// Shared definitions for the SPI to register-bank bridge.
//   CMD_WRITE / CMD_READ : SPI command opcodes
//   spi_state_e          : bridge FSM state encoding
//   decode_cmd()         : state that follows a received command byte
package fpga_template_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } spi_state_e;

    // Known commands continue with an address byte.
    // Anything else is ignored until the frame ends.
    function automatic spi_state_e decode_cmd(input logic [7:0] cmd);
        if (cmd == CMD_WRITE || cmd == CMD_READ) begin
            return ST_ADDR;
        end
        return ST_IGNORE;
    endfunction

endpackage

// File: rtl/spi_rb_bridge_if.sv
// Bus bundle between the SPI pins / register bank and the bridge.
//   sclk, cs_n, mosi, miso : SPI mode-0 pins (sclk, cs_n, mosi are asynchronous)
//   address, data_write_in : register-bank address and write data
//   data_read_out          : register-bank read data, registered by the bank
//   reg_en, write_en       : access strobes
//   busy, fsm_state        : frame activity and FSM state for observation
// Strobe semantics: reg_en is high for exactly one clk per register access.
// On a write, write_en is high in that same clk, and address/data_write_in
// are valid in that clk. On a read, the bank must present the addressed
// data on data_read_out in the clk after the reg_en clk. There is no
// back-pressure: the bank must accept every strobe.
interface spi_rb_bridge_if #(
    parameter int ADR_BITS = 8
);
    import fpga_template_pkg::*;

    logic                sclk;
    logic                cs_n;
    logic                mosi;
    logic                miso;
    logic [ADR_BITS-1:0] address;
    logic [7:0]          data_write_in;
    logic [7:0]          data_read_out;
    logic                reg_en;
    logic                write_en;
    logic                busy;
    spi_state_e          fsm_state;

    modport slave (
        input  sclk, cs_n, mosi, data_read_out,
        output miso, address, data_write_in, reg_en, write_en, busy, fsm_state
    );

    modport master (
        output sclk, cs_n, mosi, data_read_out,
        input  miso, address, data_write_in, reg_en, write_en, busy, fsm_state
    );

endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous input.
//   clk, resetb : system clock, asynchronous active-low reset
//   d_i         : asynchronous input
//   q_o         : input synchronised to clk, STAGES clocks of latency
// RST_VAL is the value the chain holds during reset. It is chosen as the
// idle level of the input, so that leaving reset does not look like an edge.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetb,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(d_i);
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_rb_bridge.sv
// SPI mode-0 slave that turns frames into register-bank accesses.
// A frame is: command byte, address byte, then one or more data bytes.
//   0x02 = write burst, 0x03 = read burst; other commands are ignored.
// Ports:
//   clk    : system clock; must run at least 8x the sclk frequency
//   resetb : asynchronous active-low reset
//   bus    : spi_rb_bridge_if.slave (SPI pins, register-bank bus, status)
module spi_rb_bridge
    import fpga_template_pkg::*;
#(
    parameter int ADR_BITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           resetb,
    spi_rb_bridge_if.slave bus
);

    localparam int SW = $clog2(SYNC_STAGES + 1);

    logic sclk_s;
    logic cs_n_s;
    logic mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .resetb(resetb), .d_i(bus.sclk), .q_o(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
        .clk(clk), .resetb(resetb), .d_i(bus.cs_n), .q_o(cs_n_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .resetb(resetb), .d_i(bus.mosi), .q_o(mosi_s)
    );

    spi_state_e          state_q, state_d;
    logic                sclk_prev_q;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          rx_q, rx_d;
    logic [7:0]          tx_q, tx_d;
    logic [ADR_BITS-1:0] address_q, address_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                reg_en_q, reg_en_d;
    logic                write_en_q, write_en_d;
    logic                rd_wait_q, rd_wait_d;
    logic                is_write_q, is_write_d;
    logic                armed_q, armed_d;
    logic [SW-1:0]       settle_q, settle_d;

    logic                sclk_rise;
    logic                sclk_fall;
    logic [7:0]          rx_byte;
    logic [ADR_BITS-1:0] adr_byte;
    logic                settled;

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign rx_byte   = {rx_q[6:0], mosi_s};
    assign settled   = (settle_q == SW'(SYNC_STAGES));

    generate
        if (ADR_BITS <= 8) begin : g_adr_narrow
            assign adr_byte = rx_byte[ADR_BITS-1:0];
        end else begin : g_adr_wide
            assign adr_byte = {{(ADR_BITS-8){1'b0}}, rx_byte};
        end
    endgenerate

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q     <= ST_IDLE;
            sclk_prev_q <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            address_q   <= '0;
            wdata_q     <= 8'h00;
            reg_en_q    <= 1'b0;
            write_en_q  <= 1'b0;
            rd_wait_q   <= 1'b0;
            is_write_q  <= 1'b0;
            armed_q     <= 1'b0;
            settle_q    <= '0;
        end else begin
            state_q     <= state_d;
            sclk_prev_q <= sclk_s;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            address_q   <= address_d;
            wdata_q     <= wdata_d;
            reg_en_q    <= reg_en_d;
            write_en_q  <= write_en_d;
            rd_wait_q   <= rd_wait_d;
            is_write_q  <= is_write_d;
            armed_q     <= armed_d;
            settle_q    <= settle_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        address_d  = address_q;
        wdata_d    = wdata_q;
        reg_en_d   = 1'b0;
        write_en_d = 1'b0;
        is_write_d = is_write_q;
        settle_d   = settle_q;
        armed_d    = armed_q;

        // After reset, the chain still holds its reset value for a few
        // clocks. cs_n must be seen high once the chain has flushed before
        // a low cs_n counts as a frame start. This way, a frame cut by
        // reset is not resumed halfway through.
        if (!settled) begin
            settle_d = settle_q + SW'(1);
        end
        if (settled && cs_n_s) begin
            armed_d = 1'b1;
        end

        // The bank saw the address during the reg_en clk and presents the
        // data one clk later. That is when the data is captured for miso.
        rd_wait_d = reg_en_q && (state_q == ST_RDATA);
        if (rd_wait_q) begin
            tx_d = bus.data_read_out;
        end else if (sclk_fall && (bit_cnt_q != 3'd0) && (state_q == ST_RDATA)) begin
            // bit_cnt_q == 0 here means the 8th bit was just taken. The
            // following fall must leave the freshly loaded byte in place.
            tx_d = {tx_q[6:0], 1'b0};
        end

        // A write burst advances the address once its strobe has gone out.
        if (write_en_q) begin
            address_d = address_q + ADR_BITS'(1);
        end

        if (cs_n_s) begin
            // The frame has ended or was never started. Any partial byte is dropped.
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            rx_d      = 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (armed_q) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 3'd0;
                    end
                end
                default: begin
                    if (sclk_rise) begin
                        rx_d      = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            case (state_q)
                                ST_CMD: begin
                                    is_write_d = (rx_byte == CMD_WRITE);
                                    state_d    = decode_cmd(rx_byte);
                                end
                                ST_ADDR: begin
                                    address_d = adr_byte;
                                    reg_en_d  = ~is_write_q;
                                    state_d   = is_write_q ? ST_WDATA : ST_RDATA;
                                end
                                ST_WDATA: begin
                                    wdata_d    = rx_byte;
                                    write_en_d = 1'b1;
                                    reg_en_d   = 1'b1;
                                end
                                ST_RDATA: begin
                                    address_d = address_q + ADR_BITS'(1);
                                    reg_en_d  = 1'b1;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign bus.miso          = (state_q == ST_RDATA) & tx_q[7];
    assign bus.address       = address_q;
    assign bus.data_write_in = wdata_q;
    assign bus.reg_en        = reg_en_q;
    assign bus.write_en      = write_en_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.fsm_state     = state_q;

endmodule
